// File: rtl/hc191_ctrl_pkg.sv
// Shared definitions for the 74HC191 run controller.
//   state_t : run sequencer states
//   TERM_UP : counter value at terminal count when counting up
//   TERM_DN : counter value at terminal count when counting down
//   STEP_W  : width of the step counter and the STEPS report
package hc191_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    STEP_HI,
    STEP_LO,
    DONE,
    FAIL
  } state_t;

  localparam logic [3:0] TERM_UP = 4'hF;
  localparam logic [3:0] TERM_DN = 4'h0;
  localparam int         STEP_W  = 5;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   i_clk      : clock
//   i_srst     : synchronous active-high reset (pointer favours requester 0)
//   i_req      : request vector, bit 0 = A, bit 1 = B
//   i_ptr_load : strobe, records i_served as the last-served requester
//   i_served   : id of the requester just served (0 = A, 1 = B)
//   o_gnt      : one-hot grant, combinational from i_req and the pointer
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic [1:0] i_req,
  input  logic       i_ptr_load,
  input  logic       i_served,
  output logic [1:0] o_gnt
);

  // Id of the requester served last; on a tie the other one wins.
  logic r_last;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_last <= 1'b1;
    end else if (i_ptr_load) begin
      r_last <= i_served;
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    if (i_req[0] && (!i_req[1] || r_last)) begin
      o_gnt = 2'b01;
    end else if (i_req[1]) begin
      o_gnt = 2'b10;
    end
  end

endmodule

// File: rtl/hc191_run_controller.sv
// Run sequencer and two-way arbiter for one shared 74HC191 counter.
// A granted requester gets a preset (LOAD), then CP pulses until the
// counter reports terminal count, or MAX_STEPS pulses have been issued.
//   i_cp                : system clock
//   i_mr                : synchronous active-high reset
//   i_req_a / i_req_b   : run requests, held until done/err
//   i_ud_a / i_ud_b     : direction (0 = up, 1 = down)
//   i_d_a / i_d_b       : preset values
//   o_gnt_a / o_gnt_b   : requester owns the counter
//   o_done_a / o_done_b : one-cycle pulse, terminal count reached
//   o_err_a / o_err_b   : one-cycle pulse, step budget exhausted
//   o_steps             : CP pulses issued in the last completed run
//   o_cnt_*             : counter control pins; i_cnt_tc is counter TC
module hc191_run_controller
  import hc191_ctrl_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 1,
  parameter int unsigned MAX_STEPS   = 16
) (
  input  logic              i_cp,
  input  logic              i_mr,
  input  logic              i_req_a,
  input  logic              i_req_b,
  input  logic              i_ud_a,
  input  logic              i_ud_b,
  input  logic [3:0]        i_d_a,
  input  logic [3:0]        i_d_b,
  output logic              o_gnt_a,
  output logic              o_gnt_b,
  output logic              o_done_a,
  output logic              o_done_b,
  output logic              o_err_a,
  output logic              o_err_b,
  output logic [STEP_W-1:0] o_steps,
  output logic              o_cnt_npl,
  output logic [3:0]        o_cnt_d,
  output logic              o_cnt_nud,
  output logic              o_cnt_nce,
  output logic              o_cnt_cp,
  input  logic              i_cnt_tc
);

  localparam int                PH_W     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(HALF_PERIOD - 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);

  state_t              r_state, w_state_next;
  logic                r_side;          // 0 = A owns the run, 1 = B
  logic [STEP_W-1:0]   r_step_cnt;
  logic [PH_W-1:0]     r_phase;

  logic                r_gnt_a, r_gnt_b, r_done_a, r_done_b, r_err_a, r_err_b;
  logic [STEP_W-1:0]   r_steps;
  logic                r_cnt_npl, r_cnt_nud, r_cnt_nce, r_cnt_cp;
  logic [3:0]          r_cnt_d;

  logic [1:0]          w_arb_gnt;
  logic                w_req_own, w_phase_end, w_abort, w_ptr_load;
  logic                w_side_next, w_busy_next, w_ud_sel;
  logic [3:0]          w_d_sel;

  rr_arbiter2 u_arb (
    .i_clk      (i_cp),
    .i_srst     (i_mr),
    .i_req      ({i_req_b, i_req_a}),
    .i_ptr_load (w_ptr_load),
    .i_served   (r_side),
    .o_gnt      (w_arb_gnt)
  );

  assign w_req_own   = r_side ? i_req_b : i_req_a;
  assign w_phase_end = (r_phase == PH_LAST);
  assign w_d_sel     = w_arb_gnt[1] ? i_d_b  : i_d_a;
  assign w_ud_sel    = w_arb_gnt[1] ? i_ud_b : i_ud_a;

  always_comb begin
    w_state_next = r_state;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_arb_gnt) w_state_next = LOAD;
      end
      LOAD, SETTLE, STEP_HI, STEP_LO: begin
        if (!w_req_own) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end else if (r_state == LOAD) begin
          w_state_next = SETTLE;
        end else if (r_state == SETTLE) begin
          w_state_next = i_cnt_tc ? DONE : STEP_HI;
        end else if (w_phase_end) begin
          // TC wins over the budget check: reaching terminal on the last
          // allowed step is a success.
          if (r_state == STEP_HI)          w_state_next = STEP_LO;
          else if (i_cnt_tc)               w_state_next = DONE;
          else if (r_step_cnt == STEP_MAX) w_state_next = FAIL;
          else                             w_state_next = STEP_HI;
        end
      end
      DONE, FAIL: w_state_next = IDLE;
      default:    w_state_next = IDLE;
    endcase
    w_ptr_load  = w_abort || (r_state == DONE) || (r_state == FAIL);
    w_side_next = (r_state == IDLE) ? w_arb_gnt[1] : r_side;
    w_busy_next = (w_state_next != IDLE);
  end

  // Outputs are registered from the next state so each pin shows the
  // value belonging to the state the FSM is in during that cycle.
  always_ff @(posedge i_cp) begin
    if (i_mr) begin
      r_state    <= IDLE;
      r_side     <= 1'b0;
      r_step_cnt <= '0;
      r_phase    <= '0;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_done_a   <= 1'b0;
      r_done_b   <= 1'b0;
      r_err_a    <= 1'b0;
      r_err_b    <= 1'b0;
      r_steps    <= '0;
      r_cnt_npl  <= 1'b1;
      r_cnt_d    <= 4'h0;
      r_cnt_nud  <= 1'b0;
      r_cnt_nce  <= 1'b1;
      r_cnt_cp   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_side  <= w_side_next;
      r_phase <= (w_state_next != r_state) ? '0 : r_phase + 1'b1;

      if (r_state == IDLE) begin
        r_step_cnt <= '0;
      end else if (w_state_next == STEP_HI && r_state != STEP_HI) begin
        r_step_cnt <= r_step_cnt + 1'b1;
      end

      // Preset and direction are latched into the pin registers on grant
      // and held there for the rest of the run.
      if (w_state_next == LOAD) begin
        r_cnt_d   <= w_d_sel;
        r_cnt_nud <= w_ud_sel;
      end

      if (w_state_next == DONE || w_state_next == FAIL) begin
        r_steps <= r_step_cnt;
      end

      r_gnt_a   <= w_busy_next && !w_side_next;
      r_gnt_b   <= w_busy_next &&  w_side_next;
      r_done_a  <= (w_state_next == DONE) && !w_side_next;
      r_done_b  <= (w_state_next == DONE) &&  w_side_next;
      r_err_a   <= (w_state_next == FAIL) && !w_side_next;
      r_err_b   <= (w_state_next == FAIL) &&  w_side_next;
      r_cnt_npl <= (w_state_next != LOAD);
      r_cnt_nce <= !w_busy_next;
      r_cnt_cp  <= (w_state_next == STEP_HI);
    end
  end

  assign o_gnt_a   = r_gnt_a;
  assign o_gnt_b   = r_gnt_b;
  assign o_done_a  = r_done_a;
  assign o_done_b  = r_done_b;
  assign o_err_a   = r_err_a;
  assign o_err_b   = r_err_b;
  assign o_steps   = r_steps;
  assign o_cnt_npl = r_cnt_npl;
  assign o_cnt_d   = r_cnt_d;
  assign o_cnt_nud = r_cnt_nud;
  assign o_cnt_nce = r_cnt_nce;
  assign o_cnt_cp  = r_cnt_cp;

endmodule

// File: tb/tb_hc191_run_controller.sv
// Self-checking bench for hc191_run_controller with a behavioural
// 74HC191 counter attached. Expected run outcomes come from the distance
// between preset and terminal count versus the step budget.
module tb_hc191_run_controller;

  localparam int HP   = 1;
  localparam int MAXS = 5;

  logic       clk = 1'b0;
  logic       mr = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, ud_a = 1'b0, ud_b = 1'b0;
  logic [3:0] d_a = 4'h0, d_b = 4'h0;
  logic       gnt_a, gnt_b, done_a, done_b, err_a, err_b;
  logic [4:0] steps;
  logic       cnt_npl, cnt_nud, cnt_nce, cnt_cp, cnt_tc;
  logic [3:0] cnt_d;
  logic       force_tc0 = 1'b0;

  int n_tests = 0, n_fail = 0, cp_pulses = 0, overlap = 0, last_side = 1;

  always #5 clk = ~clk;

  hc191_run_controller #(.HALF_PERIOD(HP), .MAX_STEPS(MAXS)) dut (
    .i_cp(clk), .i_mr(mr),
    .i_req_a(req_a), .i_req_b(req_b), .i_ud_a(ud_a), .i_ud_b(ud_b),
    .i_d_a(d_a), .i_d_b(d_b),
    .o_gnt_a(gnt_a), .o_gnt_b(gnt_b), .o_done_a(done_a), .o_done_b(done_b),
    .o_err_a(err_a), .o_err_b(err_b), .o_steps(steps),
    .o_cnt_npl(cnt_npl), .o_cnt_d(cnt_d), .o_cnt_nud(cnt_nud),
    .o_cnt_nce(cnt_nce), .o_cnt_cp(cnt_cp), .i_cnt_tc(cnt_tc)
  );

  // Behavioural counter: preset while nPL low, count on each CP rise.
  logic [3:0] q = 4'h0;
  logic       cp_d = 1'b0;
  always @(posedge clk) begin
    cp_d <= cnt_cp;
    if (!cnt_npl) q <= cnt_d;
    else if (cnt_cp && !cp_d && !cnt_nce) q <= cnt_nud ? q - 4'd1 : q + 4'd1;
  end
  assign cnt_tc = force_tc0 ? 1'b0 : (cnt_nud ? (q == 4'h0) : (q == 4'hF));

  always @(posedge cnt_cp) cp_pulses++;
  always @(negedge clk) if (cnt_cp && !cnt_npl) overlap++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: on a tie the side not served last wins.
  function automatic int pick(input logic ra, input logic rb);
    if (ra && rb) return (last_side == 0) ? 1 : 0;
    if (ra) return 0;
    if (rb) return 1;
    return -1;
  endfunction

  task automatic check_reset(input string w);
    check({w, "_gnt"},  {gnt_b, gnt_a}, 0);
    check({w, "_done"}, {done_b, done_a}, 0);
    check({w, "_err"},  {err_b, err_a}, 0);
    check({w, "_steps"}, steps, 0);
    check({w, "_npl"},  cnt_npl, 1);
    check({w, "_d"},    cnt_d, 0);
    check({w, "_nud"},  cnt_nud, 0);
    check({w, "_nce"},  cnt_nce, 1);
    check({w, "_cp"},   cnt_cp, 0);
  endtask

  // Waits for the grant of an already-requested run and checks it end to end.
  task automatic run_check(input int side, input bit keep);
    int need, exp_steps, cyc, p0, guard;
    bit exp_ok;
    logic [3:0] d, exp_q;
    logic ud;
    logic [1:0] onehot;
    d      = (side == 1) ? d_b : d_a;
    ud     = (side == 1) ? ud_b : ud_a;
    onehot = (side == 1) ? 2'b10 : 2'b01;
    need   = ud ? int'(d) : 15 - int'(d);
    if (force_tc0)        begin exp_ok = 0; exp_steps = MAXS; end
    else if (need <= MAXS) begin exp_ok = 1; exp_steps = need; end
    else                   begin exp_ok = 0; exp_steps = MAXS; end
    exp_q = ud ? d - 4'(exp_steps) : d + 4'(exp_steps);

    guard = 0;
    while (!(gnt_a || gnt_b) && guard < 20) begin @(negedge clk); guard++; end
    check("grant", {gnt_b, gnt_a}, onehot);
    check("load_npl", cnt_npl, 0);
    check("load_d", cnt_d, d);
    check("load_nud", cnt_nud, ud);
    check("load_nce", cnt_nce, 0);
    p0  = cp_pulses;
    cyc = 0;
    while (!(done_a || done_b || err_a || err_b) && cyc < 100) begin cyc++; @(negedge clk); end
    check("done", {done_b, done_a}, exp_ok ? onehot : 2'b00);
    check("err", {err_b, err_a}, exp_ok ? 2'b00 : onehot);
    check("steps", steps, exp_steps);
    check("latency", cyc, 2 + exp_steps * 2 * HP);
    check("pulses", cp_pulses - p0, exp_steps);
    check("gnt_hold", {gnt_b, gnt_a}, onehot);
    check("q_final", q, exp_q);
    $display("[TB] run side=%s d=%h ud=%0d steps=%0d/%0d %s cycles=%0d",
             (side == 1) ? "B" : "A", d, ud, steps, exp_steps, exp_ok ? "done" : "err", cyc);
    if (!keep) begin
      if (side == 1) req_b = 1'b0; else req_a = 1'b0;
    end
    @(negedge clk);
    check("gnt_drop", {gnt_b, gnt_a}, 0);
    check("pulse_len", {done_b, done_a, err_b, err_a}, 0);
    check("idle_nce", cnt_nce, 1);
    last_side = side;
  endtask

  initial begin
    int guard, p0, pat;
    repeat (3) @(negedge clk);
    check_reset("por");
    mr = 1'b0;

    // Both requesting from reset: A, then B, then A again.
    d_a = 4'hE; ud_a = 1'b0; d_b = 4'h3; ud_b = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    run_check(pick(req_a, req_b), 1'b1);
    run_check(pick(req_a, req_b), 1'b0);
    run_check(pick(req_a, req_b), 1'b0);

    // Up run of three steps.
    d_a = 4'hC; ud_a = 1'b0; req_a = 1'b1;
    run_check(pick(req_a, req_b), 1'b0);

    // Zero-step run.
    d_b = 4'h0; ud_b = 1'b1; req_b = 1'b1;
    run_check(pick(req_a, req_b), 1'b0);

    // Timeout with TC stuck low.
    force_tc0 = 1'b1;
    d_a = 4'hD; ud_a = 1'b0; req_a = 1'b1;
    run_check(pick(req_a, req_b), 1'b0);
    force_tc0 = 1'b0;

    // Abort during the second CP-high phase; B waits behind A.
    d_a = 4'h0; ud_a = 1'b0; req_a = 1'b1;
    guard = 0;
    while (!gnt_a && guard < 20) begin @(negedge clk); guard++; end
    check("abort_grant", gnt_a, 1);
    p0 = cp_pulses;
    d_b = 4'hA; ud_b = 1'b0; req_b = 1'b1;
    guard = 0;
    while (!(cnt_cp && (cp_pulses - p0) == 2) && guard < 40) begin @(negedge clk); guard++; end
    check("abort_at_hi2", cp_pulses - p0, 2);
    req_a = 1'b0;
    @(negedge clk);
    check("abort_gnt", {gnt_b, gnt_a}, 0);
    check("abort_cp", cnt_cp, 0);
    check("abort_nce", cnt_nce, 1);
    check("abort_npl", cnt_npl, 1);
    check("abort_flags", {done_b, done_a, err_b, err_a}, 0);
    $display("[TB] abort side=A after %0d steps", cp_pulses - p0);
    last_side = 0;
    run_check(pick(req_a, req_b), 1'b0);

    // Reset in the middle of a CP-high phase.
    d_a = 4'hE; ud_a = 1'b1; req_a = 1'b1;
    guard = 0;
    while (!cnt_cp && guard < 20) begin @(negedge clk); guard++; end
    check("mr_pre_cp", cnt_cp, 1);
    mr = 1'b1; req_a = 1'b0; req_b = 1'b1; d_b = 4'h2; ud_b = 1'b1;
    @(negedge clk);
    check_reset("mr_mid");
    $display("[TB] reset mid-run");
    mr = 1'b0;
    last_side = 1;
    run_check(pick(req_a, req_b), 1'b0);

    // Random request patterns and presets.
    for (int it = 0; it < 16; it++) begin
      pat  = $urandom_range(1, 3);
      d_a  = 4'($urandom); d_b = 4'($urandom);
      ud_a = 1'($urandom); ud_b = 1'($urandom);
      req_a = pat[0]; req_b = pat[1];
      run_check(pick(req_a, req_b), 1'b0);
      if (req_a || req_b) run_check(pick(req_a, req_b), 1'b0);
    end

    check("npl_cp_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
